// File: rtl/data_mem_ctrl.sv
// Data memory controller: turns load/store commands into single-beat bus
// accesses with alignment checks, lane steering, load extension and timeout.
// Ports: clk, rst (sync, active-high); MemRead, MemWrite, Funct3, Addr,
//   WriteData in; ReadData, Stall, Fault out; mem_req, mem_we, mem_addr,
//   mem_wstrb, mem_wdata out; mem_ready, mem_rdata in.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [31:0] rd_q;

  logic        cmd;
  logic        legal;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic [31:0] lane;
  logic [31:0] ext;
  logic        tmo;

  assign cmd = MemRead | MemWrite;

  // MemWrite wins when both are high, so legality is judged as a store.
  always_comb begin
    legal = 1'b0;
    unique case (Funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~Addr[0];
      3'b010:  legal = (Addr[1:0] == 2'b00);
      3'b100:  legal = ~MemWrite;
      3'b101:  legal = ~MemWrite & ~Addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    strb_d  = 4'b1111;
    wdata_d = WriteData;
    unique case (Funct3[1:0])
      2'b00: begin
        strb_d  = 4'b0001 << Addr[1:0];
        wdata_d = {4{WriteData[7:0]}};
      end
      2'b01: begin
        strb_d  = 4'b0011 << Addr[1:0];
        wdata_d = {2{WriteData[15:0]}};
      end
      default: begin
        strb_d  = 4'b1111;
        wdata_d = WriteData;
      end
    endcase
  end

  assign lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = lane;
    unique case (f3_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  // Last permitted wait cycle with no ready: this cycle is the timeout.
  assign tmo = ~mem_ready & (cnt_q == 8'(TIMEOUT - 1));

  assign Stall = ~rst & (((state_q == S_IDLE) & cmd & legal)
                        | (state_q == S_REQ));
  assign Fault = ~rst & (((state_q == S_IDLE) & cmd & ~legal)
                        | ((state_q == S_REQ) & tmo));

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = mem_req ? strb_q : 4'b0000;
  assign ReadData  = rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      rd_q    <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd & legal) begin
            f3_q    <= Funct3;
            off_q   <= Addr[1:0];
            we_q    <= MemWrite;
            addr_q  <= {Addr[31:2], 2'b00};
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            cnt_q   <= 8'd0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            if (!we_q) rd_q <= ext;
            state_q <= S_DONE;
          end else if (tmo) begin
            rd_q    <= 32'd0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum wait cycles in REQ before a fault; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 MemRead  in  1  load command from the control unit.
REQ-005 MemWrite  in  1  store command from the control unit.
REQ-006 Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 Addr  in  32  byte address from the ALU.
REQ-008 WriteData  in  32  store data from rs2.
REQ-009 ReadData  out  32  extended load result.
REQ-010 Stall  out  1  freeze PC and pipeline while high.
REQ-011 Fault  out  1  one-cycle pulse on misaligned, illegal or timed-out access.
REQ-012 mem_req  out  1  bus request; held until accepted.
REQ-013 mem_we  out  1  1 = write.
REQ-014 mem_addr  out  32  word address: Addr[31:2], 2'b00.
REQ-015 mem_wstrb  out  4  byte enables.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_ready  in  1  bus accept/complete, same cycle as mem_req.
REQ-018 mem_rdata  in  32  read word, valid when mem_ready high on a read.

Function
REQ-019 States IDLE, REQ, DONE; reset state IDLE.
REQ-020 IDLE, command seen (MemRead|MemWrite): if legal, latch Addr, Funct3, WriteData, direction; go REQ.
REQ-021 MemWrite and MemRead both high: treated as write.
REQ-022 Illegal: H/HU with Addr[0]=1; W with Addr[1:0]!=0; load Funct3 in {011,110,111}; store Funct3 not in {000,001,010}.
REQ-023 Illegal command: Fault pulses the same cycle; no bus access; Stall low; remain IDLE.
REQ-024 Stall combinational: high in IDLE on a legal command, high throughout REQ, low in DONE.
REQ-025 REQ: mem_req=1, mem_we/addr/wstrb/wdata from latched values, stable until mem_ready.
REQ-026 REQ with mem_ready=1: capture read data; go DONE.
REQ-027 Minimum latency, command to DONE: 2 cycles (ready in first REQ cycle); Stall high exactly 2 cycles.
REQ-028 Timeout: wait counter clears on REQ entry, increments each REQ cycle without ready.
REQ-029 Counter reaching TIMEOUT: Fault pulses; mem_req drops; go DONE with ReadData=0.
REQ-030 mem_ready on the timeout cycle: normal completion; no Fault.
REQ-031 DONE: lasts one cycle; ReadData valid; command inputs ignored; then IDLE.
REQ-032 Store strobes: SB 0001<<Addr[1:0]; SH 0011<<Addr[1:0]; SW 1111.
REQ-033 Store data: SB {4{WriteData[7:0]}}; SH {2{WriteData[15:0]}}; SW WriteData.
REQ-034 Load lane: mem_rdata >> (8*Addr[1:0]).
REQ-035 Load extension: B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
REQ-036 ReadData holds its last value outside DONE; store completion leaves ReadData unchanged.
REQ-037 mem_req low outside REQ; mem_wstrb=0 whenever mem_req low.

Reset
REQ-038 rst high at a clock edge: state IDLE, counter 0; ReadData, Fault, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata all 0.
REQ-039 Reset in REQ: mem_req low from the next cycle; no Fault pulse; no ReadData update.
REQ-040 Reset dominates command inputs and mem_ready in the same cycle.

Verification
REQ-041 Word load: LW Addr=0x100, mem_rdata=0x8000_00F0, ready in first REQ cycle -> Stall 2 cycles, mem_addr=0x100, ReadData=0x8000_00F0 in DONE.
REQ-042 Byte load sign and zero: LB Addr=0x103, mem_rdata=0x8A00_0000 -> ReadData=0xFFFF_FF8A; LBU same -> 0x0000_008A.
REQ-043 Byte and half store: SB Addr=0x202, WriteData=0x1234_56AB -> wstrb=0100, wdata=0xABAB_ABAB; SH Addr=0x202 -> wstrb=1100, wdata=0x56AB_56AB.
REQ-044 Misaligned: LW Addr=0x101 -> Fault 1 cycle, mem_req never high, Stall 0.
REQ-045 Timeout: TIMEOUT=4, mem_ready held 0 -> Fault after 4 REQ cycles, ReadData=0, IDLE two cycles later; ready on 4th cycle -> no Fault.
REQ-046 Reset mid-operation: rst during REQ after 2 wait cycles -> mem_req 0 next cycle, Stall 0, then a fresh LW completes normally.
